// File: rtl/mlp_neuron_mac.sv
// mlp_neuron_mac: bias + weighted-sum engine for one perceptron.
// Walks weight address 0 (bias) then 1..N_INPUTS (weights), accumulating in
// full precision, then rescales by FRAC_BITS and saturates to DATA_WIDTH.
// Optional feature macro: MLP_MAC_RELU_EN (ReLU after saturation).
module mlp_neuron_mac #(
  parameter int N_INPUTS   = 2,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int ADDR_WIDTH = $clog2(N_INPUTS + 1),
  parameter int ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(N_INPUTS + 1) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] w_rd_data,
  input  logic [DATA_WIDTH-1:0] x_rd_data,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  sat
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BIAS   = 2'd1,
    ST_MAC    = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam int PW = 2 * DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N_INPUTS);
  localparam logic [ADDR_WIDTH-1:0] ONE_ADDR  = ADDR_WIDTH'(1);
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] RES_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] RES_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_t                        r_state;
  state_t                        w_next_state;
  logic [ADDR_WIDTH-1:0]         r_addr;
  logic signed [ACC_WIDTH-1:0]   r_acc;
  logic                          r_busy;
  logic                          r_done;
  logic [DATA_WIDTH-1:0]         r_result;
  logic                          r_sat;

  logic signed [PW-1:0]          w_w_ext;
  logic signed [PW-1:0]          w_x_ext;
  logic signed [PW-1:0]          w_prod;
  logic signed [ACC_WIDTH-1:0]   w_prod_acc;
  logic signed [ACC_WIDTH-1:0]   w_bias_acc;
  logic signed [ACC_WIDTH-1:0]   w_acc_sum;
  logic signed [ACC_WIDTH-1:0]   w_y;
  logic [DATA_WIDTH-1:0]         w_sat_result;
  logic                          w_sat_flag;
  logic                          w_last;

  // Sign-extended operands, full-width product and next accumulator value.
  always_comb begin
    w_w_ext    = {{(PW-DATA_WIDTH){w_rd_data[DATA_WIDTH-1]}}, w_rd_data};
    w_x_ext    = {{(PW-DATA_WIDTH){x_rd_data[DATA_WIDTH-1]}}, x_rd_data};
    w_prod     = w_w_ext * w_x_ext;
    w_prod_acc = {{(ACC_WIDTH-PW){w_prod[PW-1]}}, w_prod};
    w_bias_acc = {{(ACC_WIDTH-DATA_WIDTH){w_rd_data[DATA_WIDTH-1]}}, w_rd_data} <<< FRAC_BITS;
    w_acc_sum  = r_acc + w_prod_acc;
    w_y        = w_acc_sum >>> FRAC_BITS;
    w_last     = (r_addr == LAST_ADDR);
  end

  // Rescaled sum narrowed to one activation word with clipping (and optional ReLU).
  always_comb begin
    w_sat_result = w_y[DATA_WIDTH-1:0];
    w_sat_flag   = 1'b0;
    if (w_y > ACC_MAX) begin
      w_sat_result = RES_MAX;
      w_sat_flag   = 1'b1;
    end else if (w_y < ACC_MIN) begin
      w_sat_result = RES_MIN;
      w_sat_flag   = 1'b1;
    end else begin
      w_sat_result = w_y[DATA_WIDTH-1:0];
      w_sat_flag   = 1'b0;
    end
`ifdef MLP_MAC_RELU_EN
    // Negative outputs (clipped or not) become zero, so only positive clips report sat.
    if (w_sat_result[DATA_WIDTH-1]) begin
      w_sat_result = {DATA_WIDTH{1'b0}};
      w_sat_flag   = 1'b0;
    end else begin
      w_sat_result = w_sat_result;
      w_sat_flag   = w_sat_flag;
    end
`else
    w_sat_result = w_sat_result;
`endif
  end

  // Next-state logic for the bias / multiply-accumulate sequence.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next_state = ST_BIAS;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_BIAS: w_next_state = ST_MAC;
      ST_MAC: begin
        if (w_last) begin
          w_next_state = ST_FINISH;
        end else begin
          w_next_state = ST_MAC;
        end
      end
      ST_FINISH: w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Datapath and output registers. The saturated result is captured on the
  // last MAC edge from the final sum so it is valid in the same cycle as done.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr   <= {ADDR_WIDTH{1'b0}};
      r_acc    <= {ACC_WIDTH{1'b0}};
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= {DATA_WIDTH{1'b0}};
      r_sat    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_addr <= {ADDR_WIDTH{1'b0}};
          r_done <= 1'b0;
          r_busy <= start;
        end
        ST_BIAS: begin
          r_acc  <= w_bias_acc;
          r_addr <= ONE_ADDR;
        end
        ST_MAC: begin
          r_acc <= w_acc_sum;
          if (w_last) begin
            r_result <= w_sat_result;
            r_sat    <= w_sat_flag;
            r_done   <= 1'b1;
          end else begin
            r_addr <= r_addr + ONE_ADDR;
          end
        end
        ST_FINISH: begin
          r_done <= 1'b0;
          r_busy <= 1'b0;
          r_addr <= {ADDR_WIDTH{1'b0}};
        end
        default: begin
          r_addr <= {ADDR_WIDTH{1'b0}};
          r_done <= 1'b0;
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign addr   = r_addr;
  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign sat    = r_sat;

endmodule

// File: tb/tb_mlp_neuron_mac.sv
// Directed, table-driven bench for mlp_neuron_mac (N_INPUTS=2, Q8.8).
module tb_mlp_neuron_mac;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  addr;
  logic [15:0] w_rd_data;
  logic [15:0] x_rd_data;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        sat;

  logic [15:0] w_mem [0:3];
  logic [15:0] x_mem [0:3];

  int n_checks;
  int n_fail;

  typedef struct {
    string       name;
    logic [15:0] bias;
    logic [15:0] w1;
    logic [15:0] w2;
    logic [15:0] x1;
    logic [15:0] x2;
    logic [15:0] exp_res;
    logic        exp_sat;
  } vec_t;

  vec_t vecs [10];

  mlp_neuron_mac dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .addr      (addr),
    .w_rd_data (w_rd_data),
    .x_rd_data (x_rd_data),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .sat       (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign w_rd_data = w_mem[addr];
  assign x_rd_data = x_mem[addr];

  // Expected values given for the linear build; ReLU zeroes negatives and drops sat.
  function automatic vec_t mk(input string nm, input logic [15:0] b, input logic [15:0] w1,
                              input logic [15:0] w2, input logic [15:0] x1, input logic [15:0] x2,
                              input logic [15:0] er, input logic es);
    vec_t v;
    v.name = nm; v.bias = b; v.w1 = w1; v.w2 = w2; v.x1 = x1; v.x2 = x2;
    v.exp_res = er; v.exp_sat = es;
`ifdef MLP_MAC_RELU_EN
    if (er[15]) begin
      v.exp_res = 16'h0000;
      v.exp_sat = 1'b0;
    end
`endif
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Loads memories, drives start in the current cycle T and follows the run
  // through T+5. Returns at the negedge inside T+5 so a following call issues
  // its start back-to-back. extra=1 adds start pulses in T+1, T+2 and T+4.
  task automatic run_vec(input vec_t v, input bit extra);
    int  done_cnt;
    int  done_at;
    bit  busy_ok;
    w_mem[0] = v.bias; w_mem[1] = v.w1; w_mem[2] = v.w2; w_mem[3] = 16'h0000;
    x_mem[0] = 16'hBEEF; x_mem[1] = v.x1; x_mem[2] = v.x2; x_mem[3] = 16'h0000;
    start = 1'b1;
    done_cnt = 0;
    done_at  = 0;
    busy_ok  = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = (extra && (k == 1 || k == 2 || k == 4)) ? 1'b1 : 1'b0;
      if (done) begin
        done_cnt++;
        done_at = k;
      end
      if (k <= 4 && !busy) busy_ok = 1'b0;
      if (k <= 3) chk({v.name, "_addr"}, {30'd0, addr}, (k == 1) ? 32'd0 : 32'(k - 1));
      if (k == 4) begin
        chk({v.name, "_result"}, {16'd0, result}, {16'd0, v.exp_res});
        chk({v.name, "_sat"}, {31'd0, sat}, {31'd0, v.exp_sat});
      end
      if (k == 5) begin
        chk({v.name, "_busy_after"}, {31'd0, busy}, 32'd0);
        chk({v.name, "_result_hold"}, {16'd0, result}, {16'd0, v.exp_res});
      end
    end
    start = 1'b0;
    chk({v.name, "_done_count"}, 32'(done_cnt), 32'd1);
    chk({v.name, "_done_cycle"}, 32'(done_at), 32'd4);
    chk({v.name, "_busy_span"}, {31'd0, busy_ok}, 32'd1);
  endtask

  initial begin
    int  stray_done;
    n_checks = 0;
    n_fail   = 0;
    rst   = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w_mem[i] = 16'h0000;
      x_mem[i] = 16'h0000;
    end

    vecs[0] = mk("basic",    16'h0100, 16'h0200, 16'hFF00, 16'h0180, 16'h0080, 16'h0380, 1'b0);
    vecs[1] = mk("posclip",  16'h7F00, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000, 16'h7FFF, 1'b1);
    vecs[2] = mk("negclip",  16'h8000, 16'h7FFF, 16'h0000, 16'h8000, 16'h0000, 16'h8000, 1'b1);
    vecs[3] = mk("negsmall", 16'h0000, 16'hFF00, 16'h0000, 16'h0200, 16'h0000, 16'hFE00, 1'b0);
    vecs[4] = mk("trunc",    16'h0000, 16'h0001, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b0);
    vecs[5] = mk("maxexact", 16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF, 1'b0);
    vecs[6] = mk("maxover",  16'h7FFF, 16'h0001, 16'h0000, 16'h0100, 16'h0000, 16'h7FFF, 1'b1);
    vecs[7] = mk("minover",  16'h8000, 16'hFFFF, 16'h0000, 16'h0001, 16'h0000, 16'h8000, 1'b1);
    vecs[8] = mk("minexact", 16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h8000, 1'b0);
    vecs[9] = mk("twoterm",  16'h0000, 16'h0100, 16'h0080, 16'h0300, 16'hFC00, 16'h0100, 1'b0);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy",   {31'd0, busy}, 32'd0);
    chk("rst_done",   {31'd0, done}, 32'd0);
    chk("rst_addr",   {30'd0, addr}, 32'd0);
    chk("rst_result", {16'd0, result}, 32'd0);
    chk("rst_sat",    {31'd0, sat}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table vectors, issued back-to-back (each start lands in the cycle after done+0)
    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i], 1'b0);
    end

    // Extra start pulses during a run must be ignored
    run_vec(vecs[0], 1'b1);

    // Reset mid-run: start at T, rst sampled at the end of T+2
    w_mem[0] = vecs[1].bias; w_mem[1] = vecs[1].w1; w_mem[2] = vecs[1].w2;
    x_mem[1] = vecs[1].x1;   x_mem[2] = vecs[1].x2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy",   {31'd0, busy}, 32'd0);
    chk("midrst_addr",   {30'd0, addr}, 32'd0);
    chk("midrst_result", {16'd0, result}, 32'd0);
    chk("midrst_sat",    {31'd0, sat}, 32'd0);
    chk("midrst_done",   {31'd0, done}, 32'd0);
    stray_done = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) stray_done++;
    end
    chk("midrst_no_done", 32'(stray_done), 32'd0);

    // Fresh computations after the aborted one
    run_vec(vecs[3], 1'b0);
    run_vec(vecs[0], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mlp_neuron_mac.md
Name: mlp_neuron_mac

Overview:
Sequencer and multiply-accumulate engine that sits directly downstream of one perceptron's weight memory. On start it walks the weight-memory address space, reads the bias at address 0 and weights at addresses 1..N_INPUTS, and multiplies each weight by the matching input activation. It accumulates the products in full precision, then rescales and saturates the sum to one fixed-point activation word. The top level instantiates one per perceptron and muxes the weight-memory address between this block (compute) and the host write path (load).

Parameters:
N_INPUTS, 2, number of inputs per perceptron (>=1)
DATA_WIDTH, 16, width of weights, activations and result, signed two's complement
FRAC_BITS, 8, fractional bits of the fixed-point format (Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS)
ADDR_WIDTH, $clog2(N_INPUTS+1), weight/activation address width
ACC_WIDTH, 2*DATA_WIDTH+$clog2(N_INPUTS+1)+1, signed accumulator width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle request to compute; sampled only in IDLE
addr  out  ADDR_WIDTH  shared read address to weight memory and activation buffer
w_rd_data  in  DATA_WIDTH  weight-memory read data, combinational from addr in the same cycle
x_rd_data  in  DATA_WIDTH  activation read data, combinational from addr in the same cycle; entry 0 unused
busy  out  1  high from the cycle after start acceptance until done inclusive
done  out  1  one-cycle pulse when result is valid
result  out  DATA_WIDTH  saturated neuron output; holds until the next done
sat  out  1  result was clipped on the last computation; updates with done

Behaviour:
- Reset: state=IDLE, addr=0, acc=0, busy=0, done=0, result=0, sat=0. Reset mid-operation aborts immediately with no done.
- States: IDLE, BIAS, MAC, FINISH.
- IDLE: addr=0. If start=1, go to BIAS; otherwise stay.
- BIAS (1 cycle): acc <= sign_extend(w_rd_data) << FRAC_BITS; x_rd_data is ignored; addr <= 1; go to MAC.
- MAC (N_INPUTS cycles): acc <= acc + signed(w_rd_data)*signed(x_rd_data), using the full 2*DATA_WIDTH product. When addr==N_INPUTS, go to FINISH; otherwise addr <= addr+1. Addr never exceeds N_INPUTS and never wraps.
- FINISH (1 cycle): y = acc >>> FRAC_BITS (arithmetic shift, truncation toward -inf). If y > 2^(DATA_WIDTH-1)-1, result=max and sat=1. If y < -2^(DATA_WIDTH-1), result=min and sat=1. Otherwise result=y[DATA_WIDTH-1:0] and sat=0. Register result and sat, pulse done=1, addr <= 0, go to IDLE.
- Latency: start in cycle T gives done in cycle T+N_INPUTS+2. Next start is accepted at T+N_INPUTS+3 at the earliest.
- Start while not in IDLE (including the FINISH/done cycle) is ignored and not queued.
- The accumulator cannot overflow at the default ACC_WIDTH. Only the final narrowing saturates.
- Weight memory is not written while busy=1. The top level guarantees this; the block does not check it.

Optional Feature:
MLP_MAC_RELU_EN.
- Defined: ReLU is applied after saturation, so a negative result is forced to 0. sat still reflects positive clipping only (negative clipping reports sat=0 because the output becomes 0).
- Undefined: the output is linear; the signed saturated result is presented as-is.

Test Plan:
- N_INPUTS=2, FRAC_BITS=8; bias=0x0100, w1=0x0200, w2=0xFF00, x1=0x0180, x2=0x0080; start at T -> addr sequence 0,1,2; done at T+4; result=0x0380 (3.5); sat=0.
- bias=0x7F00, w1=0x7FFF, x1=0x7FFF, w2=0, x2=0 -> result=0x7FFF, sat=1; then bias=0x8000, w1=0x7FFF, x1=0x8000 -> result=0x8000, sat=1.
- bias=0, w1=0xFF00, x1=0x0200, w2=0 -> result=0xFE00 without MLP_MAC_RELU_EN, 0x0000 with it; sat=0 in both cases.
- Start pulses at T+1, T+2 and T+4 (the done cycle) during a run -> exactly one done at T+4; busy stays high through T+4; no second computation begins.
- rst asserted at T+2 mid-run -> next cycle: busy=0, addr=0, result=0, sat=0, no done; a fresh start then completes normally with the correct value.
- Back-to-back: start at T+5 after done at T+4 -> second done at T+9 with a result independent of the previous run (accumulator fully reloaded from bias).
